// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-stage issue and operand-lookup bundle for the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int RW   = 3,
  parameter int NSRC = 2,
  parameter int SW   = 2
);
  logic                 iss_valid;
  logic                 iss_regwrite;
  logic [RW-1:0]        iss_dst;
  logic                 iss_is_load;
  logic [NSRC-1:0]      src_used;
  logic [NSRC*RW-1:0]   src_reg;
  logic                 stall;
  logic [NSRC*SW-1:0]   fwd_sel;
  logic                 regwrite_cur;

  modport master (
    output iss_valid, iss_regwrite, iss_dst, iss_is_load, src_used, src_reg,
    input  stall, fwd_sel, regwrite_cur
  );

  modport slave (
    input  iss_valid, iss_regwrite, iss_dst, iss_is_load, src_used, src_reg,
    output stall, fwd_sel, regwrite_cur
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shadow pipeline of in-flight register writes driving forwarding selects and decode stalls
module hazard_scoreboard #(
  parameter int NREG         = 8,
  parameter int RW           = $clog2(NREG),
  parameter int NSTAGE       = 3,
  parameter int NSRC         = 2,
  parameter int LOAD_STAGE   = 2,
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W        = 16,
  parameter int SW           = $clog2(NSTAGE + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                flush,
  hazard_scoreboard_if.slave  bus,
  output logic [NREG-1:0]     busy_vec,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [NSTAGE:1]    v;
  logic [NSTAGE:1]    ld;
  logic [RW-1:0]      dst [1:NSTAGE];
  int                 hit [NSRC];
  logic [NSRC-1:0]    hazard;
  logic [NSRC*SW-1:0] fwd_sel;
  logic               stall;
  logic               accept;

  always_comb begin
    hazard  = '0;
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      hit[i] = 0;
      // walk oldest to youngest so the lowest matching stage overrides older ones
      for (int s = NSTAGE; s >= 1; s--) begin
        if (v[s] && dst[s] == bus.src_reg[i*RW +: RW]) hit[i] = s;
      end
      if (bus.src_used[i] && hit[i] != 0) begin
        if (ld[hit[i]] && hit[i] < LOAD_STAGE) hazard[i] = 1'b1;
        else fwd_sel[i*SW +: SW] = SW'(hit[i]);
      end
    end
  end

  assign stall  = (|hazard) & ~flush;
  assign accept = bus.iss_valid & ~stall & ~hold & ~flush;

  assign bus.stall        = stall;
  assign bus.fwd_sel      = fwd_sel;
  assign bus.regwrite_cur = accept & bus.iss_regwrite;

  always_comb begin
    busy_vec = '0;
    for (int s = 1; s <= NSTAGE; s++) begin
      for (int r = 0; r < NREG; r++) begin
        if (v[s] && dst[s] == RW'(r)) busy_vec[r] = 1'b1;
      end
    end
  end

  // Flush is applied after the shift so the dropped issue and young entries die together
  always_ff @(posedge clk) begin
    if (reset) begin
      v         <= '0;
      stall_cnt <= '0;
    end else begin
      if (!hold) begin
        for (int s = 2; s <= NSTAGE; s++) v[s] <= v[s-1];
        v[1] <= accept & bus.iss_regwrite;
        if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush) begin
        for (int s = 1; s <= FLUSH_STAGES; s++) v[s] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!hold) begin
      for (int s = 2; s <= NSTAGE; s++) begin
        dst[s] <= dst[s-1];
        ld[s]  <= ld[s-1];
      end
      dst[1] <= bus.iss_dst;
      ld[1]  <= bus.iss_is_load;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed bench against an age-based in-flight write model
module tb_hazard_scoreboard;
  localparam int NREG       = 8;
  localparam int RW         = 3;
  localparam int NSTAGE     = 3;
  localparam int NSRC       = 2;
  localparam int LOAD_STAGE = 2;
  localparam int CNT_W      = 4;
  localparam int SW         = 2;
  localparam int SRCW       = NSRC * RW;
  localparam int NSLOT      = 8;

  logic              clk = 1'b0;
  logic              reset, hold, flush;
  logic              iss_valid, iss_regwrite, iss_is_load;
  logic [RW-1:0]     iss_dst;
  logic [NSRC-1:0]   src_used;
  logic [SRCW-1:0]   src_reg;
  logic [NREG-1:0]   busy_a, busy_b;
  logic [CNT_W-1:0]  cnt_a, cnt_b;

  int n_vec = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RW(RW), .NSRC(NSRC), .SW(SW)) ifa ();
  hazard_scoreboard_if #(.RW(RW), .NSRC(NSRC), .SW(SW)) ifb ();

  assign ifa.iss_valid    = iss_valid;
  assign ifa.iss_regwrite = iss_regwrite;
  assign ifa.iss_dst      = iss_dst;
  assign ifa.iss_is_load  = iss_is_load;
  assign ifa.src_used     = src_used;
  assign ifa.src_reg      = src_reg;
  assign ifb.iss_valid    = iss_valid;
  assign ifb.iss_regwrite = iss_regwrite;
  assign ifb.iss_dst      = iss_dst;
  assign ifb.iss_is_load  = iss_is_load;
  assign ifb.src_used     = src_used;
  assign ifb.src_reg      = src_reg;

  hazard_scoreboard #(.NREG(NREG), .RW(RW), .NSTAGE(NSTAGE), .NSRC(NSRC), .LOAD_STAGE(LOAD_STAGE),
                      .FLUSH_STAGES(2), .CNT_W(CNT_W), .SW(SW)) dut_a (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .bus(ifa),
    .busy_vec(busy_a), .stall_cnt(cnt_a));

  hazard_scoreboard #(.NREG(NREG), .RW(RW), .NSTAGE(NSTAGE), .NSRC(NSRC), .LOAD_STAGE(LOAD_STAGE),
                      .FLUSH_STAGES(1), .CNT_W(CNT_W), .SW(SW)) dut_b (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .bus(ifb),
    .busy_vec(busy_b), .stall_cnt(cnt_b));

  // Model: each in-flight write carries its age in cycles since issue; age equals its stage
  bit m_alive [2][NSLOT];
  int m_age   [2][NSLOT];
  int m_dst   [2][NSLOT];
  bit m_ld    [2][NSLOT];
  int m_cnt   [2];

  function automatic int fs_of(input int m);
    return (m == 0) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval(input int m, output logic e_stall, output logic [NSRC*SW-1:0] e_sel,
                            output logic [NREG-1:0] e_busy);
    logic haz;
    int   best;
    bit   best_ld;
    haz    = 1'b0;
    e_sel  = '0;
    e_busy = '0;
    for (int k = 0; k < NSLOT; k++)
      if (m_alive[m][k]) e_busy[m_dst[m][k]] = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (src_used[i]) begin
        best    = 0;
        best_ld = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
          if (m_alive[m][k] && m_dst[m][k] == int'(src_reg[i*RW +: RW]) &&
              (best == 0 || m_age[m][k] < best)) begin
            best    = m_age[m][k];
            best_ld = m_ld[m][k];
          end
        end
        if (best != 0) begin
          if (best_ld && best < LOAD_STAGE) haz = 1'b1;
          else e_sel[i*SW +: SW] = best[SW-1:0];
        end
      end
    end
    e_stall = haz & ~flush;
  endtask

  task automatic model_step(input int m);
    logic e_stall;
    logic [NSRC*SW-1:0] e_sel;
    logic [NREG-1:0] e_busy;
    bit acc, placed;
    model_eval(m, e_stall, e_sel, e_busy);
    acc = iss_valid && !e_stall && !hold && !flush;
    if (reset) begin
      for (int k = 0; k < NSLOT; k++) m_alive[m][k] = 1'b0;
      m_cnt[m] = 0;
      return;
    end
    if (!hold) begin
      for (int k = 0; k < NSLOT; k++) begin
        if (m_alive[m][k]) begin
          m_age[m][k]++;
          if (m_age[m][k] > NSTAGE) m_alive[m][k] = 1'b0;
        end
      end
      if (e_stall && m_cnt[m] < (1 << CNT_W) - 1) m_cnt[m]++;
      if (acc && iss_regwrite) begin
        placed = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
          if (!placed && !m_alive[m][k]) begin
            m_alive[m][k] = 1'b1;
            m_age[m][k]   = 1;
            m_dst[m][k]   = int'(iss_dst);
            m_ld[m][k]    = iss_is_load;
            placed        = 1'b1;
          end
        end
      end
    end
    if (flush) begin
      for (int k = 0; k < NSLOT; k++)
        if (m_alive[m][k] && m_age[m][k] <= fs_of(m)) m_alive[m][k] = 1'b0;
    end
  endtask

  task automatic compare(input int m, input logic st, input logic [NSRC*SW-1:0] sel, input logic rw,
                         input logic [NREG-1:0] busy, input logic [CNT_W-1:0] cnt);
    logic e_stall;
    logic [NSRC*SW-1:0] e_sel;
    logic [NREG-1:0] e_busy;
    logic e_rw;
    string p;
    p = (m == 0) ? "a_" : "b_";
    model_eval(m, e_stall, e_sel, e_busy);
    e_rw = iss_valid & ~e_stall & ~hold & ~flush & iss_regwrite;
    check({p, "stall"}, 32'(st), 32'(e_stall));
    check({p, "fwd_sel"}, 32'(sel), 32'(e_sel));
    check({p, "regwrite_cur"}, 32'(rw), 32'(e_rw));
    check({p, "busy_vec"}, 32'(busy), 32'(e_busy));
    check({p, "stall_cnt"}, 32'(cnt), 32'(m_cnt[m]));
  endtask

  task automatic tick();
    #2;
    if (checking) begin
      compare(0, ifa.stall, ifa.fwd_sel, ifa.regwrite_cur, busy_a, cnt_a);
      compare(1, ifb.stall, ifb.fwd_sel, ifb.regwrite_cur, busy_b, cnt_b);
    end
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input bit v, input bit rw, input int d, input bit l);
    iss_valid    = v;
    iss_regwrite = rw;
    iss_dst      = RW'(d);
    iss_is_load  = l;
  endtask

  task automatic set_src0(input bit used, input int r);
    src_used = {1'b0, used};
    src_reg  = SRCW'(r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    set_issue(0, 0, 0, 0);
    set_src0(0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic randomize_inputs();
    reset        = ($urandom_range(0, 99) < 2);
    hold         = ($urandom_range(0, 9) == 0);
    flush        = ($urandom_range(0, 9) == 0);
    iss_valid    = ($urandom_range(0, 9) < 7);
    iss_regwrite = ($urandom_range(0, 3) != 0);
    iss_dst      = RW'($urandom_range(0, NREG - 1));
    iss_is_load  = ($urandom_range(0, 2) == 0);
    src_used     = NSRC'($urandom);
    src_reg      = SRCW'($urandom);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    checking = 1'b1;
    do_reset();

    // ADD r3 walks through stages 1..3 then retires
    set_issue(1, 1, 3, 0);
    tick();
    set_issue(0, 0, 0, 0);
    set_src0(1, 3);
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("s1_sel", 32'(ifa.fwd_sel[SW-1:0]), (c == 4) ? 0 : c);
      if (c == 4) check("s1_busy", 32'(busy_a), 0);
      tick();
    end

    // load-use: one stall, then forward from stage 2
    do_reset();
    set_issue(1, 1, 2, 1);
    tick();
    set_issue(1, 1, 5, 0);
    set_src0(1, 2);
    #1;
    check("s2_stall_c1", 32'(ifa.stall), 1);
    check("s2_sel_c1", 32'(ifa.fwd_sel[SW-1:0]), 0);
    tick();
    #1;
    check("s2_stall_c2", 32'(ifa.stall), 0);
    check("s2_sel_c2", 32'(ifa.fwd_sel[SW-1:0]), 2);
    check("s2_cnt_c2", 32'(cnt_a), 1);
    tick();

    // youngest match (a load) decides over an older ALU write
    do_reset();
    set_issue(1, 1, 1, 0);
    tick();
    set_issue(1, 1, 1, 1);
    tick();
    set_issue(0, 0, 0, 0);
    set_src0(1, 1);
    #1;
    check("s3_stall", 32'(ifa.stall), 1);
    tick();

    // flush kills young writes; FLUSH_STAGES=1 keeps the stage-2 entry
    do_reset();
    set_issue(1, 1, 4, 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_issue(0, 0, 0, 0);
    set_src0(1, 4);
    #1;
    check("s4_busy_a", 32'(busy_a), 0);
    check("s4_sel_b", 32'(ifb.fwd_sel[SW-1:0]), 2);
    tick();

    // hold freezes the pipeline and blocks issue
    do_reset();
    set_issue(1, 1, 5, 0);
    tick();
    hold = 1'b1;
    set_issue(1, 1, 6, 0);
    set_src0(1, 5);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("s5_sel_hold", 32'(ifa.fwd_sel[SW-1:0]), 1);
      check("s5_rw_hold", 32'(ifa.regwrite_cur), 0);
      tick();
    end
    hold = 1'b0;
    set_issue(0, 0, 0, 0);
    tick();
    #1;
    check("s5_sel_after", 32'(ifa.fwd_sel[SW-1:0]), 2);
    check("s5_cnt", 32'(cnt_a), 0);
    tick();

    // alternating load-use stalls drive the counter into saturation
    do_reset();
    set_issue(1, 1, 2, 1);
    set_src0(1, 2);
    for (int c = 0; c < 42; c++) tick();
    #1;
    check("s6_cnt_sat", 32'(cnt_a), 15);
    tick();
    #1;
    check("s6_stall_pre_reset", 32'(ifa.stall), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("s6_cnt_reset", 32'(cnt_a), 0);
    tick();

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
